// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if: bundle between the interrupt arbiter and its environment.
//   master modport: drives raw interrupt lines, mask writes and CP0 taken/eret
//                   pulses; observes the request, granted ID and status.
//   slave modport : the arbiter side (inputs and outputs reversed).
// Signals:
//   irq_src    [N]  raw asynchronous interrupt lines, rising-edge sensitive
//   mask_we    [1]  mask write strobe
//   mask_wdata [N]  new mask, bit i = 1 enables source i
//   taken      [1]  CP0 entered the handler for the current request
//   eret       [1]  CP0 executed ERET
//   ir_out     [1]  registered interrupt request to CP0
//   irq_id     [IW] registered ID of the granted source
//   pending    [N]  pending register, unmasked view
//   mask_q     [N]  current mask
//   busy       [1]  a request is being serviced
interface irq_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  irq_src;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          taken;
  logic          eret;
  logic          ir_out;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask_q;
  logic          busy;

  modport master (
    output irq_src, mask_we, mask_wdata, taken, eret,
    input  ir_out, irq_id, pending, mask_q, busy
  );

  modport slave (
    input  irq_src, mask_we, mask_wdata, taken, eret,
    output ir_out, irq_id, pending, mask_q, busy
  );
endinterface

// File: rtl/irq_arbiter.sv
// irq_arbiter: multi-source interrupt controller feeding the single CP0
// interrupt input. Synchronises N async lines, latches rising edges as
// pending, masks them and arbitrates round-robin. One request is held
// until CP0 takes it; further requests are blocked until ERET.
// Ports:
//   clk    main clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    irq_arbiter_if.slave (sources, mask write, taken/eret, outputs)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; grant the round-robin winner if any
// REQ   | ir_out high for irq_id; wait for taken, drop if source masked
// SVC   | handler running; new edges still accumulate; wait for eret
module irq_arbiter #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  irq_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N);
  localparam logic [N-1:0] ONE_HOT0 = N'(1);
  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  hist_q;
  logic [N-1:0]  pend_q;
  logic [N-1:0]  mask_r;
  logic [IW-1:0] ptr;
  logic [IW-1:0] irq_id_q;
  logic          ir_out_q;
  logic          busy_q;

  logic [N-1:0]  src_edge;
  logic [N-1:0]  elig;
  logic [N-1:0]  pend_clr;
  logic [IW-1:0] winner;
  logic          taken_req;

  // Synchroniser chain and history flop per source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mask_r <= '0;
    else if (bus.mask_we) mask_r <= bus.mask_wdata;
  end

  assign src_edge  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign elig      = pend_q & mask_r;
  assign taken_req = (state == ST_REQ) && bus.taken;
  assign pend_clr  = taken_req ? (ONE_HOT0 << irq_id_q) : '0;

  // Round-robin search starting at ptr+1. Walking offsets from the far end
  // down to 1 leaves the nearest eligible source as the final assignment.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_w;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int off = N; off >= 1; off--) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      idx_w = IW'(idx);
      if (elig[idx_w]) winner = idx_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pend_q   <= '0;
      ptr      <= PTR_RST;
      irq_id_q <= '0;
      ir_out_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // Set wins over clear on the same bit.
      pend_q <= (pend_q & ~pend_clr) | src_edge;
      case (state)
        ST_IDLE: begin
          if (|elig) begin
            irq_id_q <= winner;
            ir_out_q <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // taken beats a simultaneous mask drop
          if (bus.taken) begin
            ptr      <= irq_id_q;
            ir_out_q <= 1'b0;
            busy_q   <= 1'b1;
            state    <= ST_SVC;
          end else if (!elig[irq_id_q]) begin
            ir_out_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_SVC: begin
          if (bus.eret) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          ir_out_q <= 1'b0;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ir_out  = ir_out_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pend_q;
  assign bus.mask_q  = mask_r;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed self-checking bench for irq_arbiter (N=4,
// SYNC_STAGES=2). Inputs change and outputs are sampled 1 ns after each
// rising clock edge.
module tb_irq_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  irq_arbiter_if #(.N(4)) bus ();

  irq_arbiter #(.N(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    step(1);
    bus.mask_we    = 1'b0;
  endtask

  task automatic pulse_taken();
    bus.taken = 1'b1;
    step(1);
    bus.taken = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.irq_src    = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.taken      = 1'b0;
    bus.eret       = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset values
    chk("rst_ir_out",  {15'd0, bus.ir_out}, 16'd0);
    chk("rst_irq_id",  {14'd0, bus.irq_id}, 16'd0);
    chk("rst_pending", {12'd0, bus.pending}, 16'd0);
    chk("rst_mask",    {12'd0, bus.mask_q}, 16'd0);
    chk("rst_busy",    {15'd0, bus.busy}, 16'd0);

    // Basic latency: source 0, mask 0001
    write_mask(4'b0001);
    chk("t1_mask", {12'd0, bus.mask_q}, 16'h1);
    bus.irq_src[0] = 1'b1;
    step(2);
    chk("t1_pend_k1", {12'd0, bus.pending}, 16'h0);
    step(1);
    chk("t1_pend_k2", {12'd0, bus.pending}, 16'h1);
    chk("t1_irout_k2", {15'd0, bus.ir_out}, 16'd0);
    step(1);
    chk("t1_irout_k3", {15'd0, bus.ir_out}, 16'd1);
    chk("t1_id_k3", {14'd0, bus.irq_id}, 16'd0);
    pulse_taken();
    chk("t1_irout_taken", {15'd0, bus.ir_out}, 16'd0);
    chk("t1_pend_taken", {12'd0, bus.pending}, 16'h0);
    chk("t1_busy", {15'd0, bus.busy}, 16'd1);
    step(3);
    chk("t1_level_once", {12'd0, bus.pending}, 16'h0);
    bus.irq_src[0] = 1'b0;
    pulse_eret();
    chk("t1_busy_eret", {15'd0, bus.busy}, 16'd0);
    step(1);
    chk("t1_irout_idle", {15'd0, bus.ir_out}, 16'd0);

    // Round robin: sources 1 and 3 together, ptr=0
    write_mask(4'b1111);
    bus.irq_src[1] = 1'b1;
    bus.irq_src[3] = 1'b1;
    step(3);
    chk("t2_pend", {12'd0, bus.pending}, 16'hA);
    step(1);
    chk("t2_irout_a", {15'd0, bus.ir_out}, 16'd1);
    chk("t2_id_a", {14'd0, bus.irq_id}, 16'd1);
    pulse_taken();
    chk("t2_pend_a", {12'd0, bus.pending}, 16'h8);
    bus.irq_src = '0;
    pulse_eret();
    chk("t2_irout_eret", {15'd0, bus.ir_out}, 16'd0);
    step(1);
    chk("t2_irout_b", {15'd0, bus.ir_out}, 16'd1);
    chk("t2_id_b", {14'd0, bus.irq_id}, 16'd3);
    pulse_taken();
    chk("t2_pend_b", {12'd0, bus.pending}, 16'h0);
    step(2);
    // ptr=3: source 0 comes before source 1
    bus.irq_src[0] = 1'b1;
    bus.irq_src[1] = 1'b1;
    step(3);
    chk("t2_pend_c", {12'd0, bus.pending}, 16'h3);
    chk("t2_busy_c", {15'd0, bus.busy}, 16'd1);
    bus.irq_src = '0;
    pulse_eret();
    step(1);
    chk("t2_id_c", {14'd0, bus.irq_id}, 16'd0);
    chk("t2_irout_c", {15'd0, bus.ir_out}, 16'd1);
    pulse_taken();
    pulse_eret();
    step(1);
    chk("t2_id_d", {14'd0, bus.irq_id}, 16'd1);
    chk("t2_irout_d", {15'd0, bus.ir_out}, 16'd1);
    pulse_taken();
    pulse_eret();
    chk("t2_pend_d", {12'd0, bus.pending}, 16'h0);

    // Masked pending, then mask enable
    write_mask(4'b0000);
    bus.irq_src[2] = 1'b1;
    step(2);
    bus.irq_src[2] = 1'b0;
    step(2);
    chk("t3_pend", {12'd0, bus.pending}, 16'h4);
    chk("t3_irout_masked", {15'd0, bus.ir_out}, 16'd0);
    write_mask(4'b0100);
    chk("t3_irout_m0", {15'd0, bus.ir_out}, 16'd0);
    step(1);
    chk("t3_irout_m1", {15'd0, bus.ir_out}, 16'd1);
    chk("t3_id", {14'd0, bus.irq_id}, 16'd2);

    // Mask drop while in REQ
    write_mask(4'b0000);
    chk("t4_irout_m0", {15'd0, bus.ir_out}, 16'd1);
    step(1);
    chk("t4_irout_drop", {15'd0, bus.ir_out}, 16'd0);
    chk("t4_pend_kept", {12'd0, bus.pending}, 16'h4);
    chk("t4_busy", {15'd0, bus.busy}, 16'd0);
    pulse_taken();
    step(1);
    chk("t4_taken_ignored", {12'd0, bus.pending}, 16'h4);
    chk("t4_irout_idle", {15'd0, bus.ir_out}, 16'd0);
    write_mask(4'b0100);
    step(1);
    chk("t4_regrant", {14'd0, bus.irq_id}, 16'd2);
    pulse_taken();
    pulse_eret();
    chk("t4_pend_clr", {12'd0, bus.pending}, 16'h0);

    // Re-pend during SVC
    write_mask(4'b0001);
    bus.irq_src[0] = 1'b1;
    step(4);
    chk("t5_irout", {15'd0, bus.ir_out}, 16'd1);
    pulse_taken();
    bus.irq_src[0] = 1'b0;
    step(3);
    bus.irq_src[0] = 1'b1;
    step(3);
    chk("t5_pend_busy", {12'd0, bus.pending}, 16'h1);
    chk("t5_busy", {15'd0, bus.busy}, 16'd1);
    bus.irq_src[0] = 1'b0;
    pulse_eret();
    step(1);
    chk("t5_rereq", {15'd0, bus.ir_out}, 16'd1);
    chk("t5_id", {14'd0, bus.irq_id}, 16'd0);
    pulse_taken();

    // Reset during SVC with pending 1010
    write_mask(4'b1111);
    bus.irq_src[1] = 1'b1;
    bus.irq_src[3] = 1'b1;
    step(3);
    chk("t6_pend", {12'd0, bus.pending}, 16'hA);
    chk("t6_busy_pre", {15'd0, bus.busy}, 16'd1);
    bus.irq_src = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_pend_rst", {12'd0, bus.pending}, 16'h0);
    chk("t6_busy_rst", {15'd0, bus.busy}, 16'd0);
    chk("t6_mask_rst", {12'd0, bus.mask_q}, 16'h0);
    chk("t6_irout_rst", {15'd0, bus.ir_out}, 16'd0);
    step(1);
    rst_n = 1'b1;
    pulse_eret();
    step(2);
    chk("t6_no_req", {15'd0, bus.ir_out}, 16'd0);
    chk("t6_pend_after", {12'd0, bus.pending}, 16'h0);

    // After reset ptr=N-1: source 0 beats source 2
    write_mask(4'b1111);
    bus.irq_src[0] = 1'b1;
    bus.irq_src[2] = 1'b1;
    step(4);
    chk("t7_irout", {15'd0, bus.ir_out}, 16'd1);
    chk("t7_id", {14'd0, bus.irq_id}, 16'd0);
    bus.irq_src = '0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Multi-source interrupt controller that sits in front of the CP0 block and drives its single external interrupt input. It synchronises N asynchronous interrupt lines, latches rising edges as pending, applies a software-written mask, and arbitrates round-robin between enabled pending sources. It holds one request towards CP0 until the handler is entered, then blocks further requests until ERET. The granted source ID is exported for the handler to read as a cause value.

## Interface
- N, default 4: number of interrupt sources (2..16).
- SYNC_STAGES, default 2: synchroniser depth per source (≥2).
- clk  in  1  main clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
- irq_src  in  N  raw asynchronous interrupt lines, rising-edge sensitive.
- mask_we  in  1  mask write strobe (CP0 write stage).
- mask_wdata  in  N  new mask; bit i = 1 enables source i.
- taken  in  1  one-cycle pulse: CP0 has jumped to the handler for the current request.
- eret  in  1  one-cycle pulse: CP0 executed ERET.
- ir_out  out  1  interrupt request to CP0 ir_in, registered.
- irq_id  out  clog2(N)  ID of the granted source, registered.
- pending  out  N  pending register, unmasked view.
- mask_q  out  N  current mask.
- busy  out  1  high in SVC state.

## Operation
- Per source: SYNC_STAGES-flop synchroniser plus one history flop; edge_i = sync_out_i & ~hist_i.
- pending[i] is set on edge_i. It is cleared only when source i is granted and taken is seen in REQ. If set and clear coincide on the same bit, set wins.
- mask_q is loaded from mask_wdata on mask_we, with effect from the next cycle.
- Eligible vector: pending & mask_q.
- Round-robin select: search upward from ptr+1 modulo N; the first eligible bit wins. ptr is updated to the winner's ID on taken.
- FSM states:
  - IDLE: ir_out=0. If eligible != 0, latch irq_id = winner and go to REQ.
  - REQ: ir_out=1. On taken, clear pending[irq_id], set ptr=irq_id, go to SVC. If the latched source is no longer eligible (mask bit cleared), return to IDLE with ir_out=0 and pending kept; taken in the same cycle has priority over the mask drop.
  - SVC: ir_out=0, busy=1. New edges keep accumulating in pending. On eret, go to IDLE.
- eret outside SVC is ignored. taken outside REQ is ignored. There is no nesting: one outstanding request at a time.
- irq_id holds its value through SVC and until the next grant.

## Timing
- Reset values: ir_out=0, irq_id=0, pending=0, mask_q=0 (all disabled), busy=0, ptr=N-1 (source 0 first), state IDLE, all synchroniser and history flops 0.
- Assertion of rst_n at any point, including mid-REQ or mid-SVC, immediately forces the reset values. Edges pending at that time are lost.
- Latency: irq_src high from before edge k gives pending set at edge k+SYNC_STAGES, and ir_out=1 with valid irq_id at edge k+SYNC_STAGES+1 (k+3 by default), when masked and FSM idle.
- After taken at edge t: ir_out=0 from t. After eret at edge e: IDLE at e, and the next grant gives ir_out=1 at e+1 if anything is eligible.
- Source pulses must be high for at least 2 clk periods to be guaranteed captured. A level held high produces one event only.
- mask_we and an edge in the same cycle: both take effect, and the grant is evaluated the following cycle.

## Test plan
- Reset, mask_wdata=4'b0001 written, irq_src[0] rises at cycle 10 -> pending=0001 at cycle 12, ir_out=1 and irq_id=0 at cycle 13; taken -> pending=0, busy=1; eret -> IDLE, ir_out stays 0.
- mask=1111, sources 1 and 3 rise in the same cycle -> irq_id=1 served first. After eret, irq_id=3 with ir_out=1 one cycle later. Then source 1 again and source 0 -> order 0 before 1 is not expected; the search is from ptr+1, so 0 is served (ptr=3).
- mask=0000, irq_src[2] pulse -> pending=0100, ir_out stays 0. Write mask=0100 -> ir_out=1 two cycles after mask_we, irq_id=2.
- In REQ for source 2, write mask=0000 before taken -> ir_out=0, pending[2] still 1, state IDLE.
- During SVC for source 0, irq_src[0] pulses again -> pending[0]=1 while busy. eret -> re-request with irq_id=0.
- rst_n low for 1 cycle while in SVC with pending=1010 -> all outputs at reset values, and a later eret produces no request.
